// File: rtl/bitcoin_miner_mc.sv
// bitcoin_miner_mc: multi-core nonce search for double SHA-256 headers.
//
// sha256_double: iterative double SHA-256 of a two-block message.
//   clk, rst (async, active-high), start (one-cycle request),
//   block0/block1 (message blocks, word 0 in bits [511:480]),
//   done (one-cycle pulse), hash2 (final digest, H0 in bits [255:224]).
//
// bitcoin_miner_mc: runs NUM_CORES sha256_double instances in lockstep over
//   consecutive nonces [nonce_start, nonce_end].
//   clk, rst_n (async, active-low), start, stop, block0, block1_tmpl,
//   target, nonce_start, nonce_end -> busy, found, found_nonce, found_hash,
//   exhausted, hash_count.

module sha256_double (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block0,
  input  logic [511:0] block1,
  output logic         done,
  output logic [255:0] hash2
);

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  // Padding for the 32-byte second-pass message: 0x80 marker, zeros, bit length 256.
  localparam logic [255:0] PAD = {32'h80000000, 192'd0, 32'h00000100};

  // Round constants; entry 63 is K[0], so the table is indexed with 63-round.
  localparam logic [63:0][31:0] K_TABLE = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] r;
    r = 256'd0;
    for (int i = 0; i < 8; i++) begin
      r[i*32 +: 32] = x[i*32 +: 32] + y[i*32 +: 32];
    end
    return r;
  endfunction

  logic         run_r;
  logic [1:0]   phase_r;
  logic [5:0]   round_r;
  logic [255:0] work_r;     // a..h, a in the top word
  logic [255:0] mid_r;      // chaining value of the current compression
  logic [511:0] win_r;      // W[t..t+15], W[t] in the top word
  logic         done_r;
  logic [255:0] hash2_r;

  logic [31:0]  a_s, b_s, c_s, d_s, e_s, f_s, g_s, h_s;
  logic [31:0]  t1_s, t2_s, w_new_s;
  logic [255:0] work_next_s, sum_s;

  assign {a_s, b_s, c_s, d_s, e_s, f_s, g_s, h_s} = work_r;
  assign t1_s = h_s + bsig1(e_s) + ((e_s & f_s) ^ (~e_s & g_s)) + K_TABLE[6'd63 - round_r] + win_r[511:480];
  assign t2_s = bsig0(a_s) + ((a_s & b_s) ^ (a_s & c_s) ^ (b_s & c_s));
  // Sliding schedule: W[t+16] from W[t+14], W[t+9], W[t+1], W[t].
  assign w_new_s = ssig1(win_r[63:32]) + win_r[223:192] + ssig0(win_r[479:448]) + win_r[511:480];
  assign work_next_s = {t1_s + t2_s, a_s, b_s, c_s, d_s + t1_s, e_s, f_s, g_s};
  assign sum_s = add8(mid_r, work_next_s);

  assign done  = done_r;
  assign hash2 = hash2_r;

  // One round per cycle; three compressions: block0, block1, then the padded first digest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_r   <= 1'b0;
      phase_r <= 2'd0;
      round_r <= 6'd0;
      work_r  <= 256'd0;
      mid_r   <= 256'd0;
      win_r   <= 512'd0;
      done_r  <= 1'b0;
      hash2_r <= 256'd0;
    end else begin
      done_r <= 1'b0;
      if (!run_r) begin
        if (start) begin
          run_r   <= 1'b1;
          phase_r <= 2'd0;
          round_r <= 6'd0;
          mid_r   <= IV;
          work_r  <= IV;
          win_r   <= block0;
        end else begin
          run_r <= 1'b0;
        end
      end else begin
        work_r  <= work_next_s;
        win_r   <= {win_r[479:0], w_new_s};
        round_r <= round_r + 6'd1;
        if (round_r == 6'd63) begin
          case (phase_r)
            2'd0: begin
              mid_r   <= sum_s;
              work_r  <= sum_s;
              win_r   <= block1;
              phase_r <= 2'd1;
            end
            2'd1: begin
              mid_r   <= IV;
              work_r  <= IV;
              win_r   <= {sum_s, PAD};
              phase_r <= 2'd2;
            end
            2'd2: begin
              hash2_r <= sum_s;
              done_r  <= 1'b1;
              run_r   <= 1'b0;
              phase_r <= 2'd0;
            end
            default: begin
              run_r   <= 1'b0;
              phase_r <= 2'd0;
            end
          endcase
        end else begin
          phase_r <= phase_r;
        end
      end
    end
  end

endmodule

module bitcoin_miner_mc #(
  parameter int NUM_CORES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic [511:0] block0,
  input  logic [511:0] block1_tmpl,
  input  logic [255:0] target,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  output logic         busy,
  output logic         found,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic         exhausted,
  output logic [63:0]  hash_count
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LAUNCH = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] DRAIN  = 3'd4;

  function automatic logic [4:0] popcount(input logic [NUM_CORES-1:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < NUM_CORES; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  logic [2:0]           state_r;
  logic [32:0]          base_r;      // 33 bits so stepping past 0xFFFFFFFF is visible
  logic [31:0]          end_r;
  logic [255:0]         target_r;
  logic [NUM_CORES-1:0] active_r, done_flag_r, core_start_r;
  logic                 busy_r, found_r, exhausted_r;
  logic [31:0]          found_nonce_r;
  logic [255:0]         found_hash_r;
  logic [63:0]          hash_count_r;

  logic                 core_rst_s;
  logic [NUM_CORES-1:0] core_done_s, active_s, flags_next_s, hit_s;
  logic [255:0]         core_hash_s [NUM_CORES];
  logic                 all_done_s, win_hit_s;
  logic [4:0]           win_idx_s;
  logic [255:0]         win_hash_s;
  logic [32:0]          base_next_s;
  logic                 unused_s;

  assign core_rst_s   = ~rst_n;
  assign unused_s     = ^block1_tmpl[31:0];
  assign flags_next_s = done_flag_r | (core_done_s & active_r);
  assign all_done_s   = ((flags_next_s & active_r) == active_r);
  assign base_next_s  = base_r + 33'(NUM_CORES);

  assign busy        = busy_r;
  assign found       = found_r;
  assign found_nonce = found_nonce_r;
  assign found_hash  = found_hash_r;
  assign exhausted   = exhausted_r;
  assign hash_count  = hash_count_r;

  genvar g;
  generate
    for (g = 0; g < NUM_CORES; g++) begin : g_core
      logic [31:0] nonce_s;
      assign nonce_s = base_r[31:0] + 32'(g);
      sha256_double u_core (
        .clk    (clk),
        .rst    (core_rst_s),
        .start  (core_start_r[g]),
        .block0 (block0),
        .block1 ({block1_tmpl[511:32], nonce_s}),
        .done   (core_done_s[g]),
        .hash2  (core_hash_s[g])
      );
    end
  endgenerate

  // Cores whose nonce base+k still lies inside the range (33-bit compare, no wrap).
  always_comb begin
    active_s = {NUM_CORES{1'b0}};
    hit_s    = {NUM_CORES{1'b0}};
    for (int k = 0; k < NUM_CORES; k++) begin
      active_s[k] = ((base_r + 33'(k)) <= {1'b0, end_r});
      hit_s[k]    = active_r[k] && (core_hash_s[k] <= target_r);
    end
  end

  // Lowest-index hitting core wins: scan downward so the lowest index is written last.
  always_comb begin
    win_hit_s  = 1'b0;
    win_idx_s  = 5'd0;
    win_hash_s = 256'd0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      win_hit_s  = win_hit_s | hit_s[k];
      win_idx_s  = hit_s[k] ? 5'(k) : win_idx_s;
      win_hash_s = hit_s[k] ? core_hash_s[k] : win_hash_s;
    end
  end

  // Search control FSM and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      base_r        <= 33'd0;
      end_r         <= 32'd0;
      target_r      <= 256'd0;
      active_r      <= {NUM_CORES{1'b0}};
      done_flag_r   <= {NUM_CORES{1'b0}};
      core_start_r  <= {NUM_CORES{1'b0}};
      busy_r        <= 1'b0;
      found_r       <= 1'b0;
      exhausted_r   <= 1'b0;
      found_nonce_r <= 32'd0;
      found_hash_r  <= 256'd0;
      hash_count_r  <= 64'd0;
    end else begin
      core_start_r <= {NUM_CORES{1'b0}};
      case (state_r)
        IDLE: begin
          if (start) begin
            base_r        <= {1'b0, nonce_start};
            end_r         <= nonce_end;
            target_r      <= target;
            found_r       <= 1'b0;
            found_nonce_r <= 32'd0;
            found_hash_r  <= 256'd0;
            exhausted_r   <= 1'b0;
            hash_count_r  <= 64'd0;
            busy_r        <= 1'b1;
            state_r       <= LAUNCH;
          end else begin
            state_r <= IDLE;
          end
        end
        LAUNCH: begin
          if (stop) begin
            busy_r      <= 1'b0;
            found_r     <= 1'b0;
            exhausted_r <= 1'b0;
            state_r     <= IDLE;
          end else if (active_s == {NUM_CORES{1'b0}}) begin
            exhausted_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            core_start_r <= active_s;
            active_r     <= active_s;
            done_flag_r  <= {NUM_CORES{1'b0}};
            state_r      <= WAIT;
          end
        end
        WAIT: begin
          done_flag_r <= flags_next_s;
          if (stop) begin
            state_r <= DRAIN;
          end else if (all_done_s) begin
            state_r <= CHECK;
          end else begin
            state_r <= WAIT;
          end
        end
        CHECK: begin
          hash_count_r <= hash_count_r + {59'd0, popcount(active_r)};
          if (win_hit_s) begin
            // A solution beats a simultaneous stop.
            found_r       <= 1'b1;
            found_nonce_r <= base_r[31:0] + {27'd0, win_idx_s};
            found_hash_r  <= win_hash_s;
            busy_r        <= 1'b0;
            state_r       <= IDLE;
          end else if (stop) begin
            busy_r      <= 1'b0;
            found_r     <= 1'b0;
            exhausted_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            base_r <= base_next_s;
            // Zero-extended end also catches a base that crossed 2^32.
            if (base_next_s > {1'b0, end_r}) begin
              exhausted_r <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= IDLE;
            end else begin
              state_r <= LAUNCH;
            end
          end
        end
        DRAIN: begin
          done_flag_r <= flags_next_s;
          if (all_done_s) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            state_r <= DRAIN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bitcoin_miner_mc.sv
// Testbench for bitcoin_miner_mc: table-driven directed searches, hand-written
// stop/reset/ignore sequences, and randomized searches against a plain SHA-256
// search model.
module tb_bitcoin_miner_mc;

  localparam int NC = 4;

  localparam logic [255:0] IV_TB = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K_TB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk, rst_n, start, stop;
  logic [511:0] block0, block1_tmpl;
  logic [255:0] target;
  logic [31:0]  nonce_start, nonce_end;
  logic         busy, found, exhausted;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic [63:0]  hash_count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0]  ns;
    logic [31:0]  ne;
    logic [255:0] tgt;
    logic         ef;
    logic [31:0]  en;
    logic         ex;
    logic [63:0]  ec;
  } vec_t;

  vec_t tbl [4];

  bitcoin_miner_mc #(.NUM_CORES(NC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .block0      (block0),
    .block1_tmpl (block1_tmpl),
    .target      (target),
    .nonce_start (nonce_start),
    .nonce_end   (nonce_end),
    .busy        (busy),
    .found       (found),
    .found_nonce (found_nonce),
    .found_hash  (found_hash),
    .exhausted   (exhausted),
    .hash_count  (hash_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression with a fully expanded 64-word schedule.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) +
           ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TB[i] + w[i];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) +
           ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    r = 256'd0;
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [255:0] dhash(input logic [511:0] b0, input logic [511:0] b1);
    logic [255:0] h1;
    h1 = compress(compress(IV_TB, b0), b1);
    return compress(IV_TB, {h1, 32'h80000000, 192'd0, 32'd256});
  endfunction

  // Search model: rounds of up to NC consecutive nonces, every in-range nonce
  // of a round is counted, the first nonce meeting the target wins.
  task automatic model_search(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tgt,
                              output logic mf, output logic [31:0] mn, output logic [255:0] mh,
                              output logic mx, output logic [63:0] mc);
    longint unsigned b, act;
    logic [255:0] h;
    mf = 1'b0; mn = 32'd0; mh = 256'd0; mx = 1'b0; mc = 64'd0;
    b = longint'(ns);
    while (b <= longint'(ne) && !mf) begin
      act = longint'(ne) - b + 1;
      if (act > NC) act = NC;
      mc = mc + act;
      for (longint unsigned k = 0; k < act; k++) begin
        h = dhash(block0, {block1_tmpl[511:32], 32'(b + k)});
        if (!mf && h <= tgt) begin
          mf = 1'b1; mn = 32'(b + k); mh = h;
        end
      end
      b = b + NC;
    end
    mx = !mf;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (busy === 1'b1 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    chk("search_terminates", {255'd0, busy}, 256'd0);
  endtask

  task automatic pulse_start(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tgt);
    nonce_start = ns; nonce_end = ne; target = tgt; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_search(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] tgt);
    @(negedge clk);
    pulse_start(ns, ne, tgt);
    wait_idle();
  endtask

  task automatic check_result(input string tag, input logic ef, input logic [31:0] en, input logic [255:0] eh,
                              input logic ex, input logic [63:0] ec);
    chk({tag, "_found"}, {255'd0, found}, {255'd0, ef});
    chk({tag, "_nonce"}, {224'd0, found_nonce}, {224'd0, en});
    chk({tag, "_hash"}, found_hash, eh);
    chk({tag, "_exhausted"}, {255'd0, exhausted}, {255'd0, ex});
    chk({tag, "_count"}, {192'd0, hash_count}, {192'd0, ec});
    chk({tag, "_exclusive"}, {255'd0, found & exhausted}, 256'd0);
  endtask

  initial begin
    logic         mf, mx;
    logic [31:0]  mn, ns, ne;
    logic [255:0] mh, tgt;
    logic [63:0]  mc;
    int           len;

    tbl[0] = '{ns: 32'd100,        ne: 32'd200,        tgt: {256{1'b1}}, ef: 1'b1, en: 32'd100, ex: 1'b0, ec: 64'd4};
    tbl[1] = '{ns: 32'd0,          ne: 32'd9,          tgt: 256'd0,      ef: 1'b0, en: 32'd0,   ex: 1'b1, ec: 64'd10};
    tbl[2] = '{ns: 32'hFFFFFFFE,   ne: 32'hFFFFFFFF,   tgt: 256'd0,      ef: 1'b0, en: 32'd0,   ex: 1'b1, ec: 64'd2};
    tbl[3] = '{ns: 32'd5,          ne: 32'd4,          tgt: 256'd0,      ef: 1'b0, en: 32'd0,   ex: 1'b1, ec: 64'd0};

    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    block0 = {16{32'h01234567}}; block1_tmpl = {16{32'h89abcdef}};
    target = 256'd0; nonce_start = 32'd0; nonce_end = 32'd0;
    repeat (2) @(negedge clk);
    check_result("reset", 1'b0, 32'd0, 256'd0, 1'b0, 64'd0);
    chk("reset_busy", {255'd0, busy}, 256'd0);
    rst_n = 1'b1;

    // Directed table.
    for (int i = 0; i < 4; i++) begin
      run_search(tbl[i].ns, tbl[i].ne, tbl[i].tgt);
      check_result($sformatf("tbl%0d", i), tbl[i].ef, tbl[i].en,
                   tbl[i].ef ? dhash(block0, {block1_tmpl[511:32], tbl[i].en}) : 256'd0,
                   tbl[i].ex, tbl[i].ec);
    end

    // Empty range: exhausted exactly two cycles after start.
    @(negedge clk);
    pulse_start(32'd5, 32'd4, 256'd0);
    chk("empty_busy_c1", {255'd0, busy}, 256'd1);
    chk("empty_exh_c1", {255'd0, exhausted}, 256'd0);
    @(negedge clk);
    chk("empty_exh_c2", {255'd0, exhausted}, 256'd1);
    chk("empty_busy_c2", {255'd0, busy}, 256'd0);
    chk("empty_count", {192'd0, hash_count}, 256'd0);

    // Start while busy and stop while idle are ignored.
    @(negedge clk);
    pulse_start(32'd100, 32'd200, {256{1'b1}});
    repeat (3) @(negedge clk);
    pulse_start(32'd500, 32'd600, 256'd0);
    wait_idle();
    chk("ignore_start_nonce", {224'd0, found_nonce}, {224'd0, 32'd100});
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
    chk("ignore_stop_found", {255'd0, found}, 256'd1);
    chk("ignore_stop_busy", {255'd0, busy}, 256'd0);
    chk("ignore_stop_count", {192'd0, hash_count}, {192'd0, 64'd4});

    // Stop mid-WAIT: busy held through DRAIN, then an immediate restart.
    @(negedge clk);
    pulse_start(32'd0, 32'd3, 256'd0);
    repeat (20) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (100) @(negedge clk);
    chk("drain_busy", {255'd0, busy}, 256'd1);
    wait_idle();
    chk("drain_found", {255'd0, found}, 256'd0);
    chk("drain_exhausted", {255'd0, exhausted}, 256'd0);
    pulse_start(32'd1000, 32'd1010, {256{1'b1}});
    chk("restart_busy", {255'd0, busy}, 256'd1);
    chk("restart_count", {192'd0, hash_count}, 256'd0);
    wait_idle();
    check_result("restart", 1'b1, 32'd1000, dhash(block0, {block1_tmpl[511:32], 32'd1000}), 1'b0, 64'd4);

    // Asynchronous reset during WAIT.
    @(negedge clk);
    pulse_start(32'd300, 32'd310, 256'd0);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {255'd0, busy}, 256'd0);
    check_result("async_rst", 1'b0, 32'd0, 256'd0, 1'b0, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_search(32'd777, 32'd790, {256{1'b1}});
    check_result("after_rst", 1'b1, 32'd777, dhash(block0, {block1_tmpl[511:32], 32'd777}), 1'b0, 64'd4);

    // Randomized searches against the model.
    for (int i = 0; i < 8; i++) begin
      block0      = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      block1_tmpl = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                     $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tgt = {8'($urandom_range(0, 255)), {248{1'b1}}};
      len = $urandom_range(0, 11);
      case (i % 4)
        1: begin
          ns = 32'hFFFFFFFF - 32'($urandom_range(0, 6));
          ne = 32'hFFFFFFFF;
        end
        2: begin
          ns = 32'($urandom_range(100, 100000));
          ne = ns - 32'($urandom_range(1, 50));
        end
        default: begin
          ns = $urandom;
          ne = (ns > 32'hFFFFFFFF - 32'(len)) ? 32'hFFFFFFFF : ns + 32'(len);
        end
      endcase
      model_search(ns, ne, tgt, mf, mn, mh, mx, mc);
      run_search(ns, ne, tgt);
      check_result($sformatf("rand%0d", i), mf, mn, mh, mx, mc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
